// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter FSM encodings, keyboard command bytes and
// the host-to-device frame layout.
package ps2_host_tx_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_INHIBIT   = 3'd1;
   localparam logic [2:0] ST_START     = 3'd2;
   localparam logic [2:0] ST_SEND      = 3'd3;
   localparam logic [2:0] ST_ACK       = 3'd4;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
   localparam logic [2:0] ST_DONE      = 3'd6;
   localparam logic [2:0] ST_ERR       = 3'd7;

   localparam logic [7:0] PS2_CMD_LEDS  = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
   localparam logic [7:0] PS2_ACK       = 8'hFA;

   // Bits after the start bit, shifted out LSB first.
   typedef struct packed {
      logic       stop;
      logic       parity;
      logic [7:0] data;
   } ps2_frame_t;

   function automatic ps2_frame_t ps2_make_frame(input logic [7:0] data);
      ps2_frame_t f;
      f.stop   = 1'b1;
      f.parity = ~^data;
      f.data   = data;
      return f;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Input conditioning for one open-drain PS/2 line: two-flop synchroniser, stability
// filter and a one-cycle strobe on each filtered high-to-low transition.
module ps2_line_filter #(
   parameter int   FILT_LEN  = 8,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic line_i,
   output logic filt_o,
   output logic fall_o
);

   localparam int             SW        = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [SW-1:0]  STAB_LAST = SW'(FILT_LEN - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          filt_q;
   logic          fall_q;
   logic [SW-1:0] stab_q;

   // Filtered value follows the synchronised line only after FILT_LEN consecutive
   // cycles of disagreement; any return to agreement restarts the count.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= RESET_VAL;
         sync2_q <= RESET_VAL;
         filt_q  <= RESET_VAL;
         fall_q  <= 1'b0;
         stab_q  <= '0;
      end else begin
         sync1_q <= line_i;
         sync2_q <= sync1_q;
         fall_q  <= 1'b0;
         if (sync2_q == filt_q) begin
            stab_q <= '0;
         end else if (stab_q == STAB_LAST) begin
            filt_q <= sync2_q;
            fall_q <= ~sync2_q;
            stab_q <= '0;
         end else begin
            stab_q <= stab_q + SW'(1);
         end
      end
   end

   assign filt_o = filt_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, issues a start bit,
// shifts a byte out on device clock falls and checks the device ACK.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  IDLE       | lines released, waiting for tx_start
//  INHIBIT    | clock pulled low for INHIBIT_CYCLES
//  START      | clock and data low for START_HOLD, then clock released
//  SEND       | device clocking; drive d0..d7, parity, stop on each fall
//  ACK        | data released; sample device ACK on the 11th fall
//  WAIT_IDLE  | wait for device to release both lines
//  DONE       | one-cycle success pulse
//  ERR        | one-cycle NACK/timeout pulse
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 2840,
   parameter int START_HOLD     = 16,
   parameter int TIMEOUT_CYCLES = 425000,
   parameter int FILT_LEN       = 8
) (
   input  logic       clk28_i,
   input  logic       reset_n_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_start_i,
   output logic       tx_busy_o,
   output logic       tx_done_o,
   output logic       tx_error_o,
   output logic       rx_inhibit_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_dat_oe_o
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int WW      = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(START_HOLD - 1);
   localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT_CYCLES);

   logic [2:0]    state_q,  state_d;
   logic [9:0]    sh_q,     sh_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [CW-1:0] cnt_q,    cnt_d;
   logic [WW-1:0] wdog_q,   wdog_d;
   logic          clk_oe_q, clk_oe_d;
   logic          dat_oe_q, dat_oe_d;

   logic          clk_filt;
   logic          clk_fall;
   logic          dat_filt;
   logic          dat_fall_unused;
   logic          watched;
   logic [WW-1:0] wdog_inc;

   ps2_line_filter #(.FILT_LEN(FILT_LEN), .RESET_VAL(1'b1)) u_clk_filt (
      .clk_i   (clk28_i),
      .rst_n_i (reset_n_i),
      .line_i  (ps2_clk_i),
      .filt_o  (clk_filt),
      .fall_o  (clk_fall)
   );

   ps2_line_filter #(.FILT_LEN(FILT_LEN), .RESET_VAL(1'b1)) u_dat_filt (
      .clk_i   (clk28_i),
      .rst_n_i (reset_n_i),
      .line_i  (ps2_dat_i),
      .filt_o  (dat_filt),
      .fall_o  (dat_fall_unused)
   );

   assign watched  = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
   assign wdog_inc = wdog_q + WW'(1);

   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      bitcnt_d = bitcnt_q;
      cnt_d    = cnt_q;
      wdog_d   = wdog_q;
      clk_oe_d = clk_oe_q;
      dat_oe_d = dat_oe_q;

      case (state_q)
         ST_IDLE: begin
            dat_oe_d = 1'b0;
            if (tx_start_i) begin
               sh_d     = ps2_make_frame(tx_data_i);
               clk_oe_d = 1'b1;
               cnt_d    = '0;
               state_d  = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               dat_oe_d = 1'b1;
               cnt_d    = '0;
               state_d  = ST_START;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_START: begin
            if (cnt_q == HOLD_LAST) begin
               clk_oe_d = 1'b0;
               wdog_d   = '0;
               bitcnt_d = '0;
               state_d  = ST_SEND;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_SEND: begin
            // The tenth fall puts the stop bit (a 1) on the line, i.e. releases data.
            if (clk_fall) begin
               dat_oe_d = ~sh_q[bitcnt_q];
               bitcnt_d = bitcnt_q + 4'd1;
               if (bitcnt_q == 4'd9) begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               if (!dat_filt) begin
                  state_d = ST_WAIT_IDLE;
               end else begin
                  clk_oe_d = 1'b0;
                  dat_oe_d = 1'b0;
                  state_d  = ST_ERR;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_filt && dat_filt) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = ST_IDLE;
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase

      // Watchdog: any fall restarts it; reaching the limit aborts the frame.
      if (watched) begin
         if (clk_fall) begin
            wdog_d = '0;
         end else if (wdog_inc == WDOG_LIMIT) begin
            wdog_d   = wdog_inc;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = ST_ERR;
         end else begin
            wdog_d = wdog_inc;
         end
      end
   end

   always_ff @(posedge clk28_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= ST_IDLE;
         sh_q     <= '0;
         bitcnt_q <= '0;
         cnt_q    <= '0;
         wdog_q   <= '0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         bitcnt_q <= bitcnt_d;
         cnt_q    <= cnt_d;
         wdog_q   <= wdog_d;
         clk_oe_q <= clk_oe_d;
         dat_oe_q <= dat_oe_d;
      end
   end

   assign tx_busy_o    = (state_q != ST_IDLE);
   assign rx_inhibit_o = tx_busy_o;
   assign tx_done_o    = (state_q == ST_DONE);
   assign tx_error_o   = (state_q == ST_ERR);
   assign ps2_clk_oe_o = clk_oe_q;
   assign ps2_dat_oe_o = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural keyboard on pulled-up lines, expected frames
// queued at stimulus time and checked by an independent monitor on done/error.
module tb_ps2_host_tx;

   localparam int INHIBIT = 2840;
   localparam int HOLD    = 16;
   localparam int TIMEOUT = 3000;
   localparam int FILT    = 8;
   localparam int H       = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       busy, done, err, rx_inh, clk_oe, dat_oe;
   logic       kb_clk = 1'b1;
   logic       kb_dat = 1'b1;
   logic       glitch = 1'b0;
   logic       ps2_clk, ps2_dat;

   assign ps2_clk = ~clk_oe & kb_clk & ~glitch;
   assign ps2_dat = ~dat_oe & kb_dat;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INHIBIT),
      .START_HOLD     (HOLD),
      .TIMEOUT_CYCLES (TIMEOUT),
      .FILT_LEN       (FILT)
   ) dut (
      .clk28_i      (clk),
      .reset_n_i    (rst_n),
      .tx_data_i    (tx_data),
      .tx_start_i   (tx_start),
      .tx_busy_o    (busy),
      .tx_done_o    (done),
      .tx_error_o   (err),
      .rx_inhibit_o (rx_inh),
      .ps2_clk_i    (ps2_clk),
      .ps2_dat_i    (ps2_dat),
      .ps2_clk_oe_o (clk_oe),
      .ps2_dat_oe_o (dat_oe)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [9:0] bits;
      bit         is_err;
      bit         chk_bits;
      bit         chk_timeout;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   logic [9:0] rx_bits = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic push_exp(input logic [9:0] bits, input bit is_err, input bit chk_bits,
                           input bit chk_timeout);
      exp_t e;
      e.bits = bits; e.is_err = is_err; e.chk_bits = chk_bits; e.chk_timeout = chk_timeout;
      exp_q.push_back(e);
   endtask

   task automatic start_tx(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      tx_data  = 8'h00;
   endtask

   // Keyboard: waits for the start bit, then produces nclk clocks sampling on rises.
   task automatic kb_frame(input int nclk, input int glitch_at, input bit ack);
      int n;
      n = 0;
      while (!(ps2_clk === 1'b1 && dat_oe === 1'b1) && n < 8000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 8000) begin
         failures++;
         $display("FAIL start_bit_wait: no start bit within %0d cycles", n);
         return;
      end
      repeat (H) @(negedge clk);
      for (int i = 0; i < nclk && i < 10; i++) begin
         kb_clk = 1'b0;
         repeat (H) @(negedge clk);
         kb_clk = 1'b1;
         rx_bits[i] = ps2_dat;
         if (i == glitch_at) begin
            repeat (10) @(negedge clk);
            glitch = 1'b1;
            repeat (3) @(negedge clk);
            glitch = 1'b0;
            repeat (H - 13) @(negedge clk);
         end else begin
            repeat (H) @(negedge clk);
         end
      end
      if (nclk > 10) begin
         if (ack) kb_dat = 1'b0;
         repeat (H) @(negedge clk);
         kb_clk = 1'b0;
         repeat (H) @(negedge clk);
         kb_clk = 1'b1;
         repeat (H) @(negedge clk);
         kb_dat = 1'b1;
      end
   endtask

   task automatic wait_idle(input int budget, input bit poke_on_done);
      int n;
      n = 0;
      while (busy === 1'b1 && n < budget) begin
         if (poke_on_done && done === 1'b1) tx_start = 1'b1;
         @(negedge clk);
         tx_start = 1'b0;
         n++;
      end
      if (busy !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL busy_wait: still busy after %0d cycles", n);
      end
      repeat (3) @(negedge clk);
   endtask

   // Monitor / scoreboard
   logic prev_oe = 1'b0;
   int   rel_cyc = 0;
   int   n_inh = 0;
   int   n_hold = 0;
   bit   pend = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (clk_oe && !prev_oe) begin n_inh = 0; n_hold = 0; end
         if (!clk_oe && prev_oe) rel_cyc = cyc;
         if (clk_oe && !dat_oe) n_inh++;
         if (clk_oe && dat_oe) n_hold++;
         prev_oe = clk_oe;
         if (rx_inh !== busy) begin
            failures++;
            $display("FAIL rx_inhibit: got %0b busy %0b", rx_inh, busy);
         end
         if (busy === 1'b0 && (clk_oe !== 1'b0 || dat_oe !== 1'b0)) begin
            failures++;
            $display("FAIL oe_while_idle: clk_oe %0b dat_oe %0b", clk_oe, dat_oe);
         end
         if (done === 1'b1 || err === 1'b1) begin
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_result: done %0b error %0b", done, err);
            end else begin
               e = exp_q.pop_front();
               chk("result_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
               chk("result_oe_released", {30'd0, clk_oe, dat_oe}, 32'd0);
               chk("inhibit_cycles", n_inh, INHIBIT);
               chk("start_hold_cycles", n_hold, HOLD);
               if (e.chk_bits) chk("frame_bits", {22'd0, rx_bits}, {22'd0, e.bits});
               if (e.chk_timeout) chk("timeout_latency", cyc - rel_cyc, TIMEOUT);
            end
            pend = 1'b1;
         end else if (pend) begin
            chk("busy_after_result", {31'd0, busy}, 32'd0);
            pend = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
      $fatal(1, "global timeout");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_state", {26'd0, busy, done, err, rx_inh, clk_oe, dat_oe}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 1: set-LEDs command
      push_exp(10'h3ED, 1'b0, 1'b1, 1'b0);
      start_tx(8'hED);
      kb_frame(11, -1, 1'b1);
      wait_idle(10000, 1'b0);

      // 2: parity 0 and parity 1, second one with tx_start poked on the DONE cycle
      push_exp(10'h201, 1'b0, 1'b1, 1'b0);
      start_tx(8'h01);
      kb_frame(11, -1, 1'b1);
      wait_idle(10000, 1'b0);
      push_exp(10'h300, 1'b0, 1'b1, 1'b0);
      start_tx(8'h00);
      kb_frame(11, -1, 1'b1);
      wait_idle(10000, 1'b1);
      chk("start_on_done_ignored", {31'd0, busy}, 32'd0);

      // 3: NACK
      push_exp(10'h355, 1'b1, 1'b1, 1'b0);
      start_tx(8'h55);
      kb_frame(11, -1, 1'b0);
      wait_idle(10000, 1'b0);

      // 4: device never clocks
      push_exp(10'h000, 1'b1, 1'b0, 1'b1);
      start_tx(8'hA3);
      wait_idle(10000, 1'b0);

      // 5: reset in the middle of the data bits, then a clean frame
      start_tx(8'h00);
      kb_frame(4, -1, 1'b1);
      chk("abort_dat_driven", {31'd0, dat_oe}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_clk_oe", {31'd0, clk_oe}, 32'd0);
      chk("abort_dat_oe", {31'd0, dat_oe}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      push_exp(10'h3FF, 1'b0, 1'b1, 1'b0);
      start_tx(8'hFF);
      kb_frame(11, -1, 1'b1);
      wait_idle(10000, 1'b0);

      // 6: tx_start while busy and a short clock glitch
      push_exp(10'h2F4, 1'b0, 1'b1, 1'b0);
      start_tx(8'hF4);
      repeat (200) @(negedge clk);
      tx_data  = 8'h12;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      tx_data  = 8'h00;
      kb_frame(11, 3, 1'b1);
      wait_idle(10000, 1'b0);

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
